// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared state encoding, default width and parity helper for serial_frame_rx
package serial_frame_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_RESYNC = 3'd4
  } state_e;

  // Even-parity bit for a word of up to 16 bits; narrower words are zero-extended.
  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_frame_out_reg.sv
// rtl/serial_frame_out_reg.sv - one-entry output register with valid/ready handshake and overrun pulse
module serial_frame_out_reg
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  // A full register can still take a new word on the edge its old word is consumed.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      if (!valid_q || ready_i) begin
        data_d  = load_data_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - start/data/parity/stop frame receiver with parity, framing and overrun flags
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              D,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              acc_q;
  logic              par_ok_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic              load_d;

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      par_ok_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (D) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
          end
        end
        ST_DATA: begin
          shift_q <= {shift_q[DATA_W-2:0], D};
          acc_q   <= acc_q ^ D;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_ok_q <= (D == acc_q);
          state_q  <= ST_STOP;
        end
        ST_STOP: begin
          // A high stop bit masks any parity result; only the framing error is reported.
          if (D) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_RESYNC;
          end else begin
            parity_err_q <= !par_ok_q;
            state_q      <= ST_IDLE;
          end
        end
        ST_RESYNC: begin
          if (!D) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign load_d = (state_q == ST_STOP) && !D && par_ok_q;

  serial_frame_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk         (clk),
    .rst_n       (RST_N),
    .load_i      (load_d),
    .load_data_i (shift_q),
    .ready_i     (data_ready),
    .data_o      (data_out),
    .valid_o     (data_valid),
    .overrun_o   (overrun)
  );

  assign busy       = (state_q != ST_IDLE);
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - scoreboard bench for serial_frame_rx (DATA_W=8 and DATA_W=4 instances)
module tb_serial_frame_rx;
  import serial_frame_pkg::*;

  localparam int EV_DATA = 1;
  localparam int EV_PERR = 2;
  localparam int EV_FERR = 3;
  localparam int EV_OVR  = 4;

  typedef struct {
    int          kind;
    logic [15:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       RST_N = 1'b0;
  logic       D = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, busy, parity_err, frame_err, overrun;

  logic       D4 = 1'b0;
  logic       ready4 = 1'b0;
  logic [3:0] data_out4;
  logic       valid4, busy4, perr4, ferr4, ovr4;

  int  n_checks = 0;
  int  n_fail = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(8)) dut (
    .clk(clk), .RST_N(RST_N), .D(D), .data_ready(data_ready),
    .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  serial_frame_rx #(.DATA_W(4)) dut4 (
    .clk(clk), .RST_N(RST_N), .D(D4), .data_ready(ready4),
    .data_out(data_out4), .data_valid(valid4), .busy(busy4),
    .parity_err(perr4), .frame_err(ferr4), .overrun(ovr4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [15:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [15:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", {16'(kind), data}, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check("event", {16'(kind), data}, {16'(e.kind), e.data});
    end
  endtask

  // Monitor: every error pulse or newly loaded word is matched against the scoreboard.
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h0;
  always @(negedge clk) begin
    if (RST_N) begin
      if (parity_err) observe(EV_PERR, 16'h0);
      if (frame_err)  observe(EV_FERR, 16'h0);
      if (overrun)    observe(EV_OVR, 16'h0);
      if (data_valid && (!prev_valid || data_out != prev_data)) observe(EV_DATA, 16'(data_out));
    end
    prev_valid = data_valid;
    prev_data  = data_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    D = b;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic flip, input logic stop,
                            input logic rdy_on_stop, output int busy_cnt);
    busy_cnt = 0;
    send_bit(1'b1);
    if (busy) busy_cnt++;
    for (int i = 7; i >= 0; i--) begin
      send_bit(data[i]);
      if (busy) busy_cnt++;
    end
    send_bit(even_parity(16'(data)) ^ flip);
    if (busy) busy_cnt++;
    D = stop;
    if (rdy_on_stop) data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    if (busy) busy_cnt++;
    D = 1'b0;
  endtask

  task automatic drain();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("drain_valid", 32'(data_valid), 32'h0);
  endtask

  int bc;

  initial begin
    RST_N = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {data_out, data_valid, busy, parity_err, frame_err, overrun}, 32'h0);
    check("reset_outputs4", {data_out4, valid4, busy4, perr4, ferr4, ovr4}, 32'h0);
    RST_N = 1'b1;
    repeat (5) send_bit(1'b0);

    // Good frame 0xA5, consumer stalled
    push(EV_DATA, 16'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, bc);
    check("busy_cycles", 32'(bc), 32'd10);
    check("a5_valid", {data_valid, data_out}, {1'b1, 8'hA5});
    drain();

    // Bad parity
    push(EV_PERR, 16'h0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, bc);
    check("perr_idle", 32'(busy), 32'h0);
    tick();
    check("perr_no_valid", 32'(data_valid), 32'h0);

    // Framing error, resync, then good 0x81
    push(EV_FERR, 16'h0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, bc);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1);
      check("resync_busy", 32'(busy), 32'h1);
    end
    send_bit(1'b0);
    check("resync_exit", 32'(busy), 32'h0);
    push(EV_DATA, 16'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, bc);
    drain();

    // Back-to-back frames with stalled consumer: overrun
    push(EV_DATA, 16'h12);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, bc);
    push(EV_OVR, 16'h0);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, bc);
    check("ovr_hold", {data_valid, data_out}, {1'b1, 8'h12});
    drain();

    // Back-to-back with ready on the second completion edge
    push(EV_DATA, 16'h12);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, bc);
    push(EV_DATA, 16'h34);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, bc);
    check("swap_valid", {data_valid, data_out}, {1'b1, 8'h34});
    drain();

    // Reset on the 4th data bit of 0xFF
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    RST_N = 1'b0;
    send_bit(1'b1);
    check("midreset_outputs", {data_out, data_valid, busy, parity_err, frame_err, overrun}, 32'h0);
    RST_N = 1'b1;
    repeat (12) send_bit(1'b0);
    check("midreset_idle", {data_valid, busy}, 32'h0);

    // DATA_W=4 instance: frame 1,1001,0,0
    D4 = 1'b1; tick();
    D4 = 1'b1; tick();
    D4 = 1'b0; tick();
    D4 = 1'b0; tick();
    D4 = 1'b1; tick();
    D4 = 1'b0; tick();
    check("w4_not_yet", 32'(valid4), 32'h0);
    D4 = 1'b0; tick();
    check("w4_word", {valid4, data_out4, perr4, ferr4, ovr4}, {25'h0, 1'b1, 4'h9, 3'b000});
    repeat (3) tick();

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
